asap2_core: RTL and testbench

Parametrised successor to the 8-bit bus CPU: a self-contained accumulator core with configurable data and address width, internal RAM with a program-load port, a fetch/execute microsequencer, conditional jumps, halt/run control, a clock-enable for single-stepping, and a strobed output port. It sits at the top of the design, below only the board-level clock/LED glue, and replaces the separate register, ALU, control and memory instances with one parametrised block.

---
 rtl/asap2_core.sv | 184 ++++++++++++++++++
 tb/tb_asap2_core.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/asap2_core.sv
// Parametrised accumulator core: internal RAM with load port, T0..T4 fetch/execute
// microsequencer, conditional jumps, halt/run control, clock enable and strobed output.
module asap2_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic [DATA_W-1:0] dbg_a,
  output logic [DATA_W-1:0] dbg_b,
  output logic [DATA_W-1:0] dbg_ir,
  output logic              dbg_zf,
  output logic              dbg_cf
);

  typedef enum logic [2:0] {S_HALT, S_T0, S_T1, S_T2, S_T3, S_T4} state_t;

  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, ir_q, ir_d, out_q, out_d;
  logic                zf_q, zf_d, cf_q, cf_d, out_valid_q, out_valid_d;

  logic [DATA_W-1:0]   ram_q [2**ADDR_W];
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_wa;
  logic [DATA_W-1:0]   ram_wd;
  logic [DATA_W-1:0]   ram_rd;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic                is_sub;
  logic                sta_we;
  logic [DATA_W-1:0]   b_op;
  logic [DATA_W:0]     alu_sum;

  assign opcode  = ir_q[DATA_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign ram_rd  = ram_q[mar_q];
  assign is_sub  = (opcode == OP_SUB);
  assign b_op    = is_sub ? ~b_q : b_q;
  // SUB as A + ~B + 1, so the top bit reads as "no borrow"
  assign alu_sum = {1'b0, a_q} + {1'b0, b_op} + {{DATA_W{1'b0}}, is_sub};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    a_d         = a_q;
    b_d         = b_q;
    ir_d        = ir_q;
    out_d       = out_q;
    zf_d        = zf_q;
    cf_d        = cf_q;
    out_valid_d = 1'b0;
    sta_we      = 1'b0;
    if (ce) begin
      case (state_q)
        S_HALT: if (run) state_d = S_T0;
        S_T0: begin
          mar_d   = pc_q;
          state_d = S_T1;
        end
        S_T1: begin
          ir_d    = ram_rd;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_T2;
        end
        S_T2: begin
          state_d = S_T0;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar_d   = operand;
              state_d = S_T3;
            end
            OP_LDI: a_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
            OP_JMP: pc_d = operand;
            OP_JC:  if (cf_q) pc_d = operand;
            OP_JZ:  if (zf_q) pc_d = operand;
            OP_OUT: begin
              out_d       = a_q;
              out_valid_d = 1'b1;
            end
            OP_HLT: state_d = S_HALT;
            default: ;
          endcase
        end
        S_T3: begin
          state_d = S_T0;
          case (opcode)
            OP_LDA: a_d = ram_rd;
            OP_ADD, OP_SUB: begin
              b_d     = ram_rd;
              state_d = S_T4;
            end
            OP_STA: sta_we = 1'b1;
            default: ;
          endcase
        end
        S_T4: begin
          a_d     = alu_sum[DATA_W-1:0];
          cf_d    = alu_sum[DATA_W];
          zf_d    = (alu_sum[DATA_W-1:0] == '0);
          state_d = S_T0;
        end
        default: state_d = S_HALT;
      endcase
    end
  end

  // Load port wins only while halted or in reset, so it never collides with STA
  always_comb begin
    ram_we = 1'b0;
    ram_wa = prog_addr;
    ram_wd = prog_data;
    if (prog_we && (state_q == S_HALT || rst)) begin
      ram_we = 1'b1;
    end else if (sta_we && !rst) begin
      ram_we = 1'b1;
      ram_wa = mar_q;
      ram_wd = a_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HALT;
      pc_q        <= '0;
      mar_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ir_q        <= '0;
      out_q       <= '0;
      zf_q        <= 1'b0;
      cf_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ir_q        <= ir_d;
      out_q       <= out_d;
      zf_q        <= zf_d;
      cf_q        <= cf_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_wa] <= ram_wd;
  end

  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == S_HALT);
  assign dbg_pc    = pc_q;
  assign dbg_a     = a_q;
  assign dbg_b     = b_q;
  assign dbg_ir    = ir_q;
  assign dbg_zf    = zf_q;
  assign dbg_cf    = cf_q;

endmodule

// File: tb/tb_asap2_core.sv
// Bench for asap2_core: ALU vector table plus hand-written program sequences,
// with out_data checked against a scoreboard queue on every out_valid pulse.
module tb_asap2_core;

  logic       clk, rst, ce, run, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] out_data, dbg_a, dbg_b, dbg_ir;
  logic [3:0] dbg_pc;
  logic       out_valid, halted, dbg_zf, dbg_cf;

  asap2_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .out_data(out_data), .out_valid(out_valid), .halted(halted),
    .dbg_pc(dbg_pc), .dbg_a(dbg_a), .dbg_b(dbg_b), .dbg_ir(dbg_ir),
    .dbg_zf(dbg_zf), .dbg_cf(dbg_cf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] alu_word;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] exp_a;
    logic       exp_cf;
    logic       exp_zf;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_pulses = 0;
  logic       prev_ov  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // All time advancement goes through here so every out_valid pulse is scored
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid) begin
      n_pulses++;
      chk("out_valid_one_clk", 32'(prev_ov), 0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: got out_data %0d expected no pulse", out_data);
      end else begin
        chk("out_data", 32'(out_data), 32'(sb.pop_front()));
      end
    end
    prev_ov = out_valid;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [3:0] addr, input logic [7:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic run_prog(input int max_cyc, input bit toggle_ce, input bit we_running,
                          output int cyc);
    ce  = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("halted_drops_on_run", 32'(halted), 0);
    cyc = 0;
    if (we_running) begin
      prog_we   = 1'b1;
      prog_addr = 4'd14;
      prog_data = 8'h00;
    end
    while (!halted && cyc < max_cyc) begin
      if (toggle_ce) ce = ~ce;
      tick();
      cyc++;
    end
    prog_we = 1'b0;
    ce      = 1'b1;
    chk("halt_reached_in_budget", 32'(halted), 1);
  endtask

  task automatic load_prog1(input logic [7:0] a_val, input logic [7:0] b_val);
    load(4'd0, 8'h1E);
    load(4'd1, 8'h2F);
    load(4'd2, 8'hE0);
    load(4'd3, 8'hF0);
    load(4'd14, a_val);
    load(4'd15, b_val);
  endtask

  initial begin
    int         cyc;
    int         p0;
    logic [7:0] prog[16];

    vecs[0] = '{8'h2F,  8'd28,  8'd14,  8'd42, 1'b0, 1'b0};
    vecs[1] = '{8'h3F,   8'd5,   8'd5,   8'd0, 1'b1, 1'b1};
    vecs[2] = '{8'h3F,   8'd3,   8'd5, 8'd254, 1'b0, 1'b0};
    vecs[3] = '{8'h2F, 8'd200, 8'd100,  8'd44, 1'b1, 1'b0};
    vecs[4] = '{8'h2F, 8'd128, 8'd128,   8'd0, 1'b1, 1'b1};
    vecs[5] = '{8'h3F,  8'd10,   8'd3,   8'd7, 1'b1, 1'b0};
    vecs[6] = '{8'h3F,   8'd0,   8'd1, 8'd255, 1'b0, 1'b0};
    vecs[7] = '{8'h2F, 8'd255,   8'd1,   8'd0, 1'b1, 1'b1};

    rst = 1'b1; ce = 1'b1; run = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_halted", 32'(halted), 1);
    chk("rst_pc", 32'(dbg_pc), 0);
    chk("rst_a", 32'(dbg_a), 0);
    chk("rst_b", 32'(dbg_b), 0);
    chk("rst_ir", 32'(dbg_ir), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_flags", 32'({dbg_zf, dbg_cf, out_valid}), 0);

    // LDA 14 / ADD|SUB 15 / OUT / HLT over a table of operand pairs
    foreach (vecs[i]) begin
      do_reset();
      load_prog1(vecs[i].a_in, vecs[i].b_in);
      load(4'd1, vecs[i].alu_word);
      p0 = n_pulses;
      sb.push_back(vecs[i].exp_a);
      run_prog(100, 1'b0, 1'b0, cyc);
      chk("alu_cycles", 32'(cyc), 15);
      chk("alu_a", 32'(dbg_a), 32'(vecs[i].exp_a));
      chk("alu_cf", 32'(dbg_cf), 32'(vecs[i].exp_cf));
      chk("alu_zf", 32'(dbg_zf), 32'(vecs[i].exp_zf));
      chk("alu_pc", 32'(dbg_pc), 4);
      chk("alu_pulses", 32'(n_pulses - p0), 1);
    end

    // JZ taken after 5-5, then JC not taken after 3-5
    prog = '{8'h1E, 8'h3F, 8'h88, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0,
             8'h1D, 8'h3E, 8'h73, 8'hE0, 8'hF0, 8'h03, 8'h05, 8'h05};
    do_reset();
    for (int unsigned k = 0; k < 16; k++) load(4'(k), prog[k]);
    sb.push_back(8'd254);
    run_prog(200, 1'b0, 1'b0, cyc);
    chk("jump_cycles", 32'(cyc), 30);
    chk("jump_pc", 32'(dbg_pc), 13);
    chk("jump_flags", 32'({dbg_cf, dbg_zf}), 0);

    // PC wrap: halt at 14 leaves PC=15, then NOPs step 15 -> 0 -> 1 (HLT)
    do_reset();
    load(4'd0, 8'h6E);
    load(4'd14, 8'hF0);
    load(4'd15, 8'h00);
    run_prog(50, 1'b0, 1'b0, cyc);
    chk("wrap_pc_first", 32'(dbg_pc), 15);
    load(4'd0, 8'h00);
    load(4'd1, 8'hF0);
    run_prog(50, 1'b0, 1'b0, cyc);
    chk("wrap_cycles", 32'(cyc), 9);
    chk("wrap_pc", 32'(dbg_pc), 2);

    // STA then LDA of the same address
    do_reset();
    load(4'd0, 8'h59);
    load(4'd1, 8'h4D);
    load(4'd2, 8'h50);
    load(4'd3, 8'h1D);
    load(4'd4, 8'hE0);
    load(4'd5, 8'hF0);
    load(4'd13, 8'h77);
    sb.push_back(8'd9);
    run_prog(100, 1'b0, 1'b0, cyc);
    chk("sta_lda_cycles", 32'(cyc), 20);
    chk("sta_lda_a", 32'(dbg_a), 9);

    // ce toggling; run ignored while ce=0; load port ignored while running
    do_reset();
    load_prog1(8'd28, 8'd14);
    ce  = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("run_ignored_ce0", 32'(halted), 1);
    sb.push_back(8'd42);
    p0 = n_pulses;
    run_prog(200, 1'b1, 1'b1, cyc);
    chk("ce_cycles", 32'(cyc), 30);
    chk("ce_a", 32'(dbg_a), 42);
    chk("ce_pulses", 32'(n_pulses - p0), 1);
    do_reset();
    sb.push_back(8'd42);
    run_prog(100, 1'b0, 1'b0, cyc);
    chk("ram_kept_a", 32'(dbg_a), 42);

    // Reset at T3 of ADD, with a concurrent load fixing RAM[15]
    do_reset();
    load_prog1(8'd28, 8'd1);
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (7) tick();
    chk("pre_rst_a", 32'(dbg_a), 28);
    rst = 1'b1; prog_we = 1'b1; prog_addr = 4'd15; prog_data = 8'd14;
    tick();
    rst = 1'b0; prog_we = 1'b0;
    chk("midrst_halted", 32'(halted), 1);
    chk("midrst_regs", 32'({dbg_pc, dbg_a, dbg_b, dbg_ir}), 0);
    chk("midrst_out", 32'({out_data, out_valid, dbg_zf, dbg_cf}), 0);
    sb.push_back(8'd42);
    run_prog(100, 1'b0, 1'b0, cyc);
    chk("midrst_rerun_cycles", 32'(cyc), 15);
    chk("midrst_rerun_a", 32'(dbg_a), 42);

    tick();
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
